// File: rtl/wave_capture_buffer.sv
// Two-bank waveform capture buffer.
// A capture arms on a positive zero crossing of the incoming samples and
// fills the bank that is not on display. It then holds until the display
// asks for a bank swap at the end of its frame. Samples are stored as
// two's complement and converted to offset binary on the read side.
module wave_capture_buffer #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_ready,
    input  logic [WIDTH-1:0]     sample_in,
    input  logic                 flip,
    input  logic [ADDR_BITS-1:0] read_addr,
    output logic [WIDTH-1:0]     read_sample,
    output logic                 capture_done,
    output logic                 read_bank
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        ARMED,
        ACTIVE,
        WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   write_ptr_q, write_ptr_d;
    logic [WIDTH-1:0]       prev_sample_q, prev_sample_d;
    logic                   read_bank_q, read_bank_d;
    logic                   capture_done_q, capture_done_d;
    logic [WIDTH-1:0]       read_sample_q, read_sample_d;

    logic                   crossing;
    logic                   wr_en;
    logic [ADDR_BITS:0]     wr_addr;
    logic [WIDTH-1:0]       rd_word;

    // Two banks; the bank index is the top address bit. Never reset.
    logic [WIDTH-1:0]       mem [2*DEPTH];

    // Next-state, write control and read-side conversion.
    always_comb begin
        state_d        = state_q;
        write_ptr_d    = write_ptr_q;
        prev_sample_d  = prev_sample_q;
        read_bank_d    = read_bank_q;
        wr_en          = 1'b0;
        wr_addr        = {~read_bank_q, write_ptr_q};

        crossing = sample_ready && prev_sample_q[WIDTH-1] && !sample_in[WIDTH-1];

        unique case (state_q)
            ARMED: begin
                if (crossing) begin
                    wr_en       = 1'b1;
                    wr_addr     = {~read_bank_q, {ADDR_BITS{1'b0}}};
                    write_ptr_d = ADDR_BITS'(1);
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sample_ready) begin
                    wr_en       = 1'b1;
                    // The pointer wraps to 0 naturally on the final write.
                    write_ptr_d = write_ptr_q + 1'b1;
                    if (write_ptr_q == {ADDR_BITS{1'b1}}) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flip) begin
                    read_bank_d = ~read_bank_q;
                    state_d     = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase

        if (sample_ready) begin
            prev_sample_d = sample_in;
        end

        capture_done_d = (state_d == WAIT);

        // Read uses the bank on display this cycle; the MSB flip turns
        // two's complement into offset binary.
        rd_word                    = mem[{read_bank_q, read_addr}];
        read_sample_d              = rd_word;
        read_sample_d[WIDTH-1]     = ~rd_word[WIDTH-1];
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ARMED;
            write_ptr_q    <= '0;
            prev_sample_q  <= '0;
            read_bank_q    <= 1'b0;
            capture_done_q <= 1'b0;
            read_sample_q  <= '0;
        end else begin
            state_q        <= state_d;
            write_ptr_q    <= write_ptr_d;
            prev_sample_q  <= prev_sample_d;
            read_bank_q    <= read_bank_d;
            capture_done_q <= capture_done_d;
            read_sample_q  <= read_sample_d;
        end
    end

    // Sample storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= sample_in;
        end
    end

    assign read_sample  = read_sample_q;
    assign capture_done = capture_done_q;
    assign read_bank    = read_bank_q;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Bench for wave_capture_buffer: directed scenarios plus random traffic,
// checked every cycle against a behavioural capture model.
module tb_wave_capture_buffer;

    localparam int W  = 8;
    localparam int AB = 8;
    localparam int D  = 256;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sample_ready = 1'b0;
    logic [W-1:0]  sample_in = '0;
    logic          flip = 1'b0;
    logic [AB-1:0] read_addr = '0;
    logic [W-1:0]  read_sample;
    logic          capture_done;
    logic          read_bank;

    wave_capture_buffer #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_ready (sample_ready),
        .sample_in    (sample_in),
        .flip         (flip),
        .read_addr    (read_addr),
        .read_sample  (read_sample),
        .capture_done (capture_done),
        .read_bank    (read_bank)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 0;

    // Behavioural model: phase 0 = waiting for trigger, 1 = filling, 2 = full.
    int          m_phase;
    int          m_count;
    int          m_bank;
    logic [W-1:0] m_prev;
    logic [W-1:0] m_mem [2*D];
    bit          m_valid [2*D];
    logic [W-1:0] m_rs;
    bit          m_rs_known;
    bit          m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_count    = 0;
        m_bank     = 0;
        m_prev     = '0;
        m_rs       = '0;
        m_rs_known = 1;
        m_done     = 0;
    endtask

    task automatic model_write(input int addr, input logic [W-1:0] v);
        m_mem[addr]   = v;
        m_valid[addr] = 1;
    endtask

    // One rising edge of the reference behaviour, using the held inputs.
    task automatic model_step();
        int key;
        int wbase;
        key        = m_bank * D + int'(read_addr);
        m_rs_known = m_valid[key];
        m_rs       = m_mem[key] ^ 8'h80;
        wbase      = (1 - m_bank) * D;
        if (m_phase == 0) begin
            if (sample_ready && m_prev[W-1] && !sample_in[W-1]) begin
                model_write(wbase, sample_in);
                m_count = 1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (sample_ready) begin
                model_write(wbase + m_count, sample_in);
                m_count++;
                if (m_count == D) begin
                    m_count = 0;
                    m_phase = 2;
                end
            end
        end else if (flip) begin
            m_bank  = 1 - m_bank;
            m_phase = 0;
        end
        if (sample_ready) m_prev = sample_in;
        m_done = (m_phase == 2);
    endtask

    // Advance one cycle; returns just after the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic strobe(input logic [W-1:0] v, input bit f);
        sample_ready = 1'b1;
        sample_in    = v;
        flip         = f;
        tick();
        sample_ready = 1'b0;
        flip         = 1'b0;
    endtask

    task automatic pulse_flip();
        flip = 1'b1;
        tick();
        flip = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_read_sample", read_sample, 0);
        check("rst_capture_done", capture_done, 0);
        check("rst_read_bank", read_bank, 0);
        tick();
        reset_n = 1'b1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            check("capture_done", capture_done, m_done);
            check("read_bank", read_bank, m_bank);
            if (m_rs_known) check("read_sample", read_sample, m_rs);
        end
    end

    initial begin
        for (int i = 0; i < 2*D; i++) m_valid[i] = 0;
        model_reset();
        #1;
        run_cmp = 1;
        repeat (2) tick();
        check("reset_read_sample", read_sample, 0);
        check("reset_capture_done", capture_done, 0);
        check("reset_read_bank", read_bank, 0);
        reset_n = 1'b1;
        tick();
        check("release_idle_done", capture_done, 0);

        // Non-negative samples only: must never trigger; flips in ARMED ignored.
        strobe(8'd0, 1'b0);
        strobe(8'd1, 1'b1);
        strobe(8'd2, 1'b0);
        for (int i = 0; i < 300; i++) strobe(8'(i % 128), (i % 50) == 7);
        check("no_trigger_done", capture_done, 0);
        check("no_trigger_bank", read_bank, 0);
        check("no_trigger_phase", m_phase, 0);

        // Trigger: -5 then +3.
        strobe(8'hFB, 1'b0);
        strobe(8'h03, 1'b0);
        check("trig_word0_model", m_mem[D], 8'h03);
        check("trig_phase_model", m_phase, 1);
        check("trig_done", capture_done, 0);

        // Fill the rest with a ramp; flips in ACTIVE, including the last write.
        for (int i = 1; i < D - 1; i++) strobe(8'(i), (i % 40) == 3);
        check("pre_last_done", capture_done, 0);
        strobe(8'hFF, 1'b1);
        check("last_write_done", capture_done, 1);
        check("last_write_bank", read_bank, 0);

        // In WAIT: strobes (including a crossing) must not write.
        strobe(8'hF0, 1'b0);
        strobe(8'h05, 1'b0);
        for (int i = 0; i < 20; i++) strobe(8'($urandom), 1'b0);
        check("wait_done_holds", capture_done, 1);

        // Swap banks, then read index 0 of the new display bank.
        read_addr = '0;
        pulse_flip();
        check("flip_bank", read_bank, 1);
        check("flip_done", capture_done, 0);
        tick();
        check("flip_read0", read_sample, 8'h83);
        read_addr = 8'd1;
        tick();
        check("flip_read1", read_sample, 8'h81);
        read_addr = 8'd200;
        tick();
        check("flip_read200", read_sample, 8'h48);
        for (int i = 0; i < D; i++) begin
            read_addr = 8'(i);
            tick();
        end

        // Start a capture into bank 0, abandon it at write_ptr 100.
        strobe(8'hFF, 1'b0);
        strobe(8'h07, 1'b0);
        for (int i = 1; i < 100; i++) strobe(8'(i + 10), 1'b0);
        async_reset();
        tick();
        check("post_reset_done", capture_done, 0);

        // Next capture lands in bank 1 from index 0.
        strobe(8'hFE, 1'b0);
        strobe(8'h09, 1'b0);
        for (int i = 1; i < D; i++) strobe(8'(i ^ 8'h5A), 1'b0);
        check("recap_done", capture_done, 1);
        read_addr = '0;
        pulse_flip();
        tick();
        check("recap_read0", read_sample, 8'h89);
        check("recap_bank", read_bank, 1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            sample_ready = 1'($urandom_range(0, 1));
            sample_in    = 8'($urandom);
            flip         = ($urandom_range(0, 15) == 0);
            read_addr    = 8'($urandom);
            tick();
        end
        sample_ready = 1'b0;
        flip = 1'b0;
        tick();
        run_cmp = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wave_capture_buffer.md
WAVE_CAPTURE_BUFFER -- requirements
Module: wave_capture_buffer

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, sample width in bits; it is the same WIDTH as the downstream multiplier's val input.
REQ-002 The block SHALL provide parameter ADDR_BITS, default 8, log2 of samples per capture (DEPTH = 2^ADDR_BITS).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 sample_ready  input  1  one-cycle strobe; sample_in valid this cycle.
REQ-006 sample_in  input  WIDTH  signed two's-complement audio sample.
REQ-007 flip  input  1  one-cycle strobe from display at end of frame; requests a bank swap.
REQ-008 read_addr  input  ADDR_BITS  display read index into the displayed bank.
REQ-009 read_sample  output  WIDTH  unsigned offset-binary sample at read_addr; feeds multiplier val.
REQ-010 capture_done  output  1  high while in state WAIT.
REQ-011 read_bank  output  1  index of the bank currently being displayed.

Function
REQ-012 The block SHALL hold storage of 2*DEPTH words of WIDTH bits, organised as two banks of DEPTH words.
REQ-013 Write bank SHALL be ~read_bank; write address SHALL be {~read_bank, write_ptr}; read address SHALL be {read_bank, read_addr}.
REQ-014 The FSM SHALL have exactly three states: ARMED, ACTIVE, WAIT.
REQ-015 prev_sample SHALL be loaded with sample_in on every sample_ready, in every state.
REQ-016 Positive zero crossing SHALL be defined as sample_ready && prev_sample[WIDTH-1]==1 && sample_in[WIDTH-1]==0.
REQ-017 ARMED: on a positive crossing, the block SHALL write sample_in at write_ptr=0, set write_ptr=1 and go to ACTIVE; otherwise it SHALL stay in ARMED with no write.
REQ-018 ACTIVE: each sample_ready SHALL write sample_in at write_ptr and increment write_ptr; cycles without sample_ready SHALL change nothing.
REQ-019 ACTIVE: the write at write_ptr=DEPTH-1 SHALL complete, write_ptr SHALL wrap to 0, and the FSM SHALL go to WAIT on the same edge.
REQ-020 WAIT: sample_ready SHALL NOT write memory (prev_sample still updates); on flip the block SHALL toggle read_bank and go to ARMED.
REQ-021 flip SHALL be ignored (not latched) in ARMED and ACTIVE, including flip coincident with the final ACTIVE write.
REQ-022 The block SHALL store samples as written; conversion SHALL happen on read: read_sample = stored word with MSB inverted (two's complement to offset binary).
REQ-023 read_sample SHALL be registered, with 1-cycle latency from read_addr.
REQ-024 A read of the displayed bank SHALL never observe a write from the same capture, because reads and writes are in different banks at all times.
REQ-025 read_addr SHALL be valid every cycle; all ADDR_BITS values are legal and no range check is needed.

Reset
REQ-026 On reset_n low, the block SHALL asynchronously set state=ARMED, write_ptr=0, prev_sample=0, read_bank=0, read_sample=0 and capture_done=0.
REQ-027 Memory contents SHALL NOT be cleared by reset; after reset, reads of the displayed bank return undefined data until the first flip.
REQ-028 Reset asserted mid-ACTIVE SHALL abandon the partial capture; after release the block SHALL re-arm and overwrite from index 0 of bank 1.
REQ-029 Deassertion SHALL be clean: no write and no state change on the first edge after release unless sample_ready is high.

Verification
REQ-030 Bench: reset, feed sample_in -5, then +3 with strobes -> capture starts; word 0 of bank 1 = 8'h03 and state ACTIVE.
REQ-031 Bench: complete 256 strobes with ramp values 0..255 after trigger -> capture_done rises on the edge of the 256th write; further strobes leave memory unchanged.
REQ-032 Bench: in WAIT pulse flip, then read_addr=0 -> read_bank=1, and after 1 cycle read_sample = 8'h83 (8'h03 with MSB inverted); state ARMED.
REQ-033 Bench: pulse flip during ARMED and ACTIVE, including on the last write -> no bank swap; capture_done still rises normally.
REQ-034 Bench: assert reset_n low at write_ptr=100 -> all outputs 0 immediately; next trigger writes from index 0 of bank 1.
REQ-035 Bench: send samples 0, +1, +2 with no negative sample after reset (prev_sample=0) -> no trigger; state remains ARMED.
